// File: rtl/mem_wb_skid_reg_if.sv
// MEM/WB handshake bundle: MEM-side entry in, WB-side registered entry out.
// slave is the pipeline register's view; master is the surrounding pipeline's view.
interface mem_wb_skid_reg_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RADDR_W  = 5,
   parameter int unsigned WBCTRL_W = 2
);
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   read_data_in;
   logic [DATA_W-1:0]   addr_in;
   logic [RADDR_W-1:0]  rd_in;
   logic [WBCTRL_W-1:0] wbctrl_in;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   read_data_out;
   logic [DATA_W-1:0]   addr_out;
   logic [RADDR_W-1:0]  rd_out;
   logic [WBCTRL_W-1:0] wbctrl_out;
   logic [DATA_W-1:0]   wb_data_out;
   logic                reg_write_out;

   modport master (
      output in_valid, read_data_in, addr_in, rd_in, wbctrl_in, out_ready,
      input  in_ready, out_valid, read_data_out, addr_out, rd_out, wbctrl_out,
             wb_data_out, reg_write_out
   );

   modport slave (
      input  in_valid, read_data_in, addr_in, rd_in, wbctrl_in, out_ready,
      output in_ready, out_valid, read_data_out, addr_out, rd_out, wbctrl_out,
             wb_data_out, reg_write_out
   );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush and writeback mux.
// Optional MEMWB_STALL_CNT_EN adds a saturating 16-bit WB stall counter output.
module mem_wb_skid_reg #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RADDR_W  = 5,
   parameter int unsigned WBCTRL_W = 2  // bit 1 RegWrite, bit 0 MemToReg; must be >= 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   mem_wb_skid_reg_if.slave  bus
`ifdef MEMWB_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   // Encoding is {out_valid, skid_valid}; 2'b01 cannot occur.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StOne   = 2'b10,
      StFull  = 2'b11
   } state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0]   read_data_q, addr_q, skid_read_data_q, skid_addr_q;
   logic [RADDR_W-1:0]  rd_q, skid_rd_q;
   logic [WBCTRL_W-1:0] wbctrl_q, skid_wbctrl_q;

   logic out_valid, skid_valid, accept, drain;
   logic load_out_in, load_out_skid, load_skid;

   assign out_valid  = state_q[1];
   assign skid_valid = state_q[0];
   assign accept     = bus.in_valid & bus.in_ready;
   assign drain      = out_valid & bus.out_ready;

   always_comb begin
      state_d       = state_q;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  load_out_in = 1'b1;
                  state_d     = StOne;
               end
            end
            StOne: begin
               if (drain && accept) begin
                  load_out_in = 1'b1;
               end else if (drain) begin
                  state_d = StEmpty;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_d   = StFull;
               end
            end
            StFull: begin
               if (drain) begin
                  load_out_skid = 1'b1;
                  state_d       = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         read_data_q      <= '0;
         addr_q           <= '0;
         rd_q             <= '0;
         wbctrl_q         <= '0;
         skid_read_data_q <= '0;
         skid_addr_q      <= '0;
         skid_rd_q        <= '0;
         skid_wbctrl_q    <= '0;
      end else begin
         if (load_out_in) begin
            read_data_q <= bus.read_data_in;
            addr_q      <= bus.addr_in;
            rd_q        <= bus.rd_in;
            wbctrl_q    <= bus.wbctrl_in;
         end else if (load_out_skid) begin
            read_data_q <= skid_read_data_q;
            addr_q      <= skid_addr_q;
            rd_q        <= skid_rd_q;
            wbctrl_q    <= skid_wbctrl_q;
         end else if (flush) begin
            // Only the control field is squashed; data and rd keep their last value.
            wbctrl_q <= '0;
         end
         if (load_skid) begin
            skid_read_data_q <= bus.read_data_in;
            skid_addr_q      <= bus.addr_in;
            skid_rd_q        <= bus.rd_in;
            skid_wbctrl_q    <= bus.wbctrl_in;
         end
      end
   end

   assign bus.in_ready      = ~skid_valid & ~rst;
   assign bus.out_valid     = out_valid;
   assign bus.read_data_out = read_data_q;
   assign bus.addr_out      = addr_q;
   assign bus.rd_out        = rd_q;
   assign bus.wbctrl_out    = wbctrl_q;
   assign bus.wb_data_out   = wbctrl_q[0] ? read_data_q : addr_q;
   assign bus.reg_write_out = out_valid & wbctrl_q[1];

`ifdef MEMWB_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (out_valid && !bus.out_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: stimulus pushes expected entries, a negedge
// monitor pops and compares on every WB drain.
module tb_mem_wb_skid_reg;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [4:0]  rd;
      logic [1:0]  wbctrl;
   } entry_t;

   logic clk;
   logic rst;
   logic flush;
`ifdef MEMWB_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   entry_t exp_q[$];

   mem_wb_skid_reg_if #(.DATA_W(32), .RADDR_W(5), .WBCTRL_W(2)) bus ();

   mem_wb_skid_reg #(.DATA_W(32), .RADDR_W(5), .WBCTRL_W(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
`ifdef MEMWB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [1:0] wbctrl, input bit push);
      entry_t e;
      bus.in_valid     = 1'b1;
      bus.rd_in        = rd;
      bus.addr_in      = addr;
      bus.read_data_in = rdata;
      bus.wbctrl_in    = wbctrl;
      e.rd = rd; e.addr = addr; e.rdata = rdata; e.wbctrl = wbctrl;
      if (push) exp_q.push_back(e);
   endtask

   // Monitor: every drain must match the oldest expected entry.
   always @(negedge clk) begin
      entry_t e;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_drain", {27'd0, bus.rd_out}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("drain_rd", {27'd0, bus.rd_out}, {27'd0, e.rd});
               check("drain_addr", bus.addr_out, e.addr);
               check("drain_rdata", bus.read_data_out, e.rdata);
               check("drain_wbctrl", {30'd0, bus.wbctrl_out}, {30'd0, e.wbctrl});
               check("drain_wb_data", bus.wb_data_out, e.wbctrl[0] ? e.rdata : e.addr);
               check("drain_reg_write", {31'd0, bus.reg_write_out}, {31'd0, e.wbctrl[1]});
            end
         end else if (!bus.out_valid) begin
            check("idle_reg_write", {31'd0, bus.reg_write_out}, 32'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.rd_in = '0;
      bus.addr_in = '0;
      bus.read_data_in = '0;
      bus.wbctrl_in = '0;

      // Reset state
      step();
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
      check("rst_addr_out", bus.addr_out, 32'd0);
      check("rst_wbctrl_out", {30'd0, bus.wbctrl_out}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Streaming at full rate
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(5'(i + 1), 32'h10 * (i + 1), 32'h1000 + i, 2'b10, 1'b1);
         check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
         step();
         check("stream_out_valid", {31'd0, bus.out_valid}, 32'd1);
         check("stream_addr_out", bus.addr_out, 32'h10 * (i + 1));
      end
      bus.in_valid = 1'b0;
      step();
      check("stream_empty", {31'd0, bus.out_valid}, 32'd0);

      // Back-pressure into the skid register
      bus.out_ready = 1'b0;
      send(5'd3, 32'hA0, 32'hA5, 2'b10, 1'b1);
      step();
      check("bp_one_rd", {27'd0, bus.rd_out}, 32'd3);
      check("bp_one_in_ready", {31'd0, bus.in_ready}, 32'd1);
      send(5'd4, 32'hB0, 32'hB5, 2'b10, 1'b1);
      step();
      bus.in_valid = 1'b0;
      check("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_full_rd", {27'd0, bus.rd_out}, 32'd3);
      step();
      check("bp_hold_rd", {27'd0, bus.rd_out}, 32'd3);
      bus.out_ready = 1'b1;
      #1;
      check("bp_ready_no_comb_path", {31'd0, bus.in_ready}, 32'd0);
      step();
      check("bp_second_rd", {27'd0, bus.rd_out}, 32'd4);
      check("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
      step();
      check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

      // Writeback mux
      bus.out_ready = 1'b0;
      send(5'd5, 32'h100, 32'hDEADBEEF, 2'b11, 1'b1);
      step();
      check("mux_load_data", bus.wb_data_out, 32'hDEADBEEF);
      check("mux_load_regwrite", {31'd0, bus.reg_write_out}, 32'd1);
      bus.out_ready = 1'b1;
      send(5'd6, 32'h100, 32'hDEADBEEF, 2'b10, 1'b1);
      step();
      check("mux_alu_data", bus.wb_data_out, 32'h100);
      check("mux_alu_regwrite", {31'd0, bus.reg_write_out}, 32'd1);
      send(5'd7, 32'h100, 32'hDEADBEEF, 2'b00, 1'b1);
      step();
      check("mux_nowrite", {31'd0, bus.reg_write_out}, 32'd0);
      bus.in_valid = 1'b0;
      step();
      check("mux_drained", {31'd0, bus.out_valid}, 32'd0);

      // Flush in FULL with a live input
      bus.out_ready = 1'b0;
      send(5'd8, 32'hC0, 32'hC5, 2'b10, 1'b1);
      step();
      send(5'd9, 32'hD0, 32'hD5, 2'b11, 1'b1);
      step();
      send(5'd10, 32'hE0, 32'hE5, 2'b10, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("flush_reg_write", {31'd0, bus.reg_write_out}, 32'd0);
      check("flush_wbctrl", {30'd0, bus.wbctrl_out}, 32'd0);
      check("flush_rd_hold", {27'd0, bus.rd_out}, 32'd8);
      bus.out_ready = 1'b1;
      send(5'd11, 32'hF0, 32'hF5, 2'b10, 1'b1);
      step();
      bus.in_valid = 1'b0;
      check("post_flush_valid", {31'd0, bus.out_valid}, 32'd1);
      check("post_flush_rd", {27'd0, bus.rd_out}, 32'd11);
      step();
      check("post_flush_drained", {31'd0, bus.out_valid}, 32'd0);

      // Flush with a simultaneous drain: the drained entry still counts
      bus.out_ready = 1'b0;
      send(5'd12, 32'h120, 32'h125, 2'b10, 1'b1);
      step();
      bus.out_ready = 1'b1;
      send(5'd13, 32'h130, 32'h135, 2'b10, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_drain_empty", {31'd0, bus.out_valid}, 32'd0);

      // Reset mid-stall, with flush also high so reset priority is visible
      bus.out_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      send(5'd14, 32'h140, 32'h145, 2'b10, 1'b1);
      step();
      send(5'd15, 32'h150, 32'h155, 2'b10, 1'b1);
      step();
      bus.in_valid = 1'b0;
      repeat (4) step();
      check("stall_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
`ifdef MEMWB_STALL_CNT_EN
      check("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
`endif
      rst = 1'b1;
      flush = 1'b1;
      #1;
      check("rst_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      step();
      exp_q.delete();
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_rd_out", {27'd0, bus.rd_out}, 32'd0);
      check("midrst_addr_out", bus.addr_out, 32'd0);
      check("midrst_rdata_out", bus.read_data_out, 32'd0);
      check("midrst_wb_data", bus.wb_data_out, 32'd0);
`ifdef MEMWB_STALL_CNT_EN
      check("midrst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      rst = 1'b0;
      flush = 1'b0;
      #1;
      check("midrst_in_ready_back", {31'd0, bus.in_ready}, 32'd1);

`ifdef MEMWB_STALL_CNT_EN
      // Counter saturation
      send(5'd16, 32'h160, 32'h165, 2'b10, 1'b1);
      step();
      bus.in_valid = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      check("sat_stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);
      repeat (3) step();
      check("sat_stall_hold", {16'd0, stall_cnt}, 32'hFFFF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
`endif

      step();
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
